// File: rtl/tnn_feature_frontend_if.sv
// tnn_feature_frontend_if: raw feature beat channel and classifier result channel
interface tnn_feature_frontend_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       res_valid;
  logic       res_ready;
  logic       res_class;
  logic       res_err;
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_class, res_err
  );
  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_class, res_err
  );
endinterface

// File: rtl/tnn_feature_frontend.sv
// tnn_feature_frontend: quantise 8-bit feature beats to 2-bit codes, pack eight for the classifier and return its decision; TNN_THRESH_LOAD_EN adds per-feature threshold registers
module tnn_feature_frontend #(
  parameter logic [7:0] TH0 = 8'd64,
  parameter logic [7:0] TH1 = 8'd128,
  parameter logic [7:0] TH2 = 8'd192,
  parameter int EVAL_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  tnn_feature_frontend_if.slave        bus,
  output logic [15:0]                  feat_vec,
  input  logic                         cls_in
`ifdef TNN_THRESH_LOAD_EN
  ,
  input  logic                         cfg_we,
  input  logic [4:0]                   cfg_addr,
  input  logic [7:0]                   cfg_wdata
`endif
);
  typedef enum logic [1:0] {COLLECT, EVAL, OUT} state_t;
  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       err_pend;
  logic [7:0] t0, t1, t2;
  logic [1:0] code;
  logic       take;
  if (TH0 > TH1 || TH1 > TH2) begin : g_th_order
    $error("tnn_feature_frontend: thresholds must satisfy TH0 <= TH1 <= TH2");
  end
  if (EVAL_WAIT < 1 || EVAL_WAIT > 15) begin : g_wait_range
    $error("tnn_feature_frontend: EVAL_WAIT must be 1..15");
  end
`ifdef TNN_THRESH_LOAD_EN
  logic [7:0] th [8][3];
  // per-feature thresholds, writable in any state; select 3 is reserved
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        th[i][0] <= TH0;
        th[i][1] <= TH1;
        th[i][2] <= TH2;
      end
    end else if (cfg_we && cfg_addr[1:0] != 2'd3) th[cfg_addr[4:2]][cfg_addr[1:0]] <= cfg_wdata;
  assign t0 = th[idx][0];
  assign t1 = th[idx][1];
  assign t2 = th[idx][2];
`else
  assign t0 = TH0;
  assign t1 = TH1;
  assign t2 = TH2;
`endif
  assign code = 2'(bus.in_data >= t0) + 2'(bus.in_data >= t1) + 2'(bus.in_data >= t2);
  assign take = bus.in_valid && bus.in_ready;
  // collect eight codes, hold them for the classifier, then hand the decision out
  always_ff @(posedge clk)
    if (rst) begin
      state         <= COLLECT;
      idx           <= '0;
      cnt           <= '0;
      err_pend      <= 1'b0;
      feat_vec      <= '0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_class <= 1'b0;
      bus.res_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          bus.in_ready <= 1'b1;
          if (take) begin
            feat_vec[{idx, 1'b0} +: 2] <= code;
            idx <= idx + 3'd1;
            if (bus.in_last || idx == 3'd7) begin
              err_pend     <= !(bus.in_last && idx == 3'd7);
              cnt          <= 4'(EVAL_WAIT);
              bus.in_ready <= 1'b0;
              state        <= EVAL;
            end
          end
        end
        EVAL:
          if (cnt == 4'd0) begin
            bus.res_class <= cls_in;
            bus.res_err   <= err_pend;
            bus.res_valid <= 1'b1;
            state         <= OUT;
          end else cnt <= cnt - 4'd1;
        OUT:
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            idx           <= '0;
            err_pend      <= 1'b0;
            feat_vec      <= '0;
            state         <= COLLECT;
          end
        default: state <= COLLECT;
      endcase
    end
endmodule

// File: tb/tb_tnn_feature_frontend.sv
// tb_tnn_feature_frontend: directed and randomized checks of the feature front end against a quantise-and-pack reference model
module tb_tnn_feature_frontend;
  localparam int EW = 1;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        cls_in;
  logic [15:0] feat_vec;
  logic [15:0] ev;
  logic        ee;
  int          checks = 0;
  int          errors = 0;
  int          thr [8][3];
  int          vals [8];
  tnn_feature_frontend_if bus();
`ifdef TNN_THRESH_LOAD_EN
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
`endif
  tnn_feature_frontend #(.EVAL_WAIT(EW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .feat_vec(feat_vec),
    .cls_in(cls_in)
`ifdef TNN_THRESH_LOAD_EN
    ,
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata)
`endif
  );
  assign cls_in = mode ? ^feat_vec : feat_vec[15];
  always #5 clk = ~clk;

  function automatic logic [1:0] q(input int f, input int x);
    return 2'((x >= thr[f][0] ? 1 : 0) + (x >= thr[f][1] ? 1 : 0) + (x >= thr[f][2] ? 1 : 0));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run(input int n, input int lp);
    int c = 0;
    ev = '0;
    for (int k = 0; k < n; k++) begin
      ev[2*k +: 2] = q(k, vals[k]);
      beat(8'(vals[k]), k == lp);
    end
    ee = !(n == 8 && lp == 7);
    while (!bus.res_valid && c < 40) begin
      tick();
      c++;
    end
    check("latency", 32'(c), 32'(EW + 1));
    check("feat_vec", 32'(feat_vec), 32'(ev));
    check("res_class", 32'(bus.res_class), 32'(mode ? ^ev : ev[15]));
    check("res_err", 32'(bus.res_err), 32'(ee));
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic result(input int hold);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_vec", 32'(feat_vec), 32'(ev));
      check("hold_class", 32'(bus.res_class), 32'(mode ? ^ev : ev[15]));
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("post_hs_valid", 32'(bus.res_valid), 32'd0);
    check("post_hs_ready", 32'(bus.in_ready), 32'd1);
    check("post_hs_vec", 32'(feat_vec), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_class"}, 32'(bus.res_class), 32'd0);
    check({tag, "_res_err"}, 32'(bus.res_err), 32'd0);
    check({tag, "_feat_vec"}, 32'(feat_vec), 32'd0);
  endtask

`ifdef TNN_THRESH_LOAD_EN
  task automatic cfg(input int f, input int s, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = {3'(f), 2'(s)};
    cfg_wdata = 8'(d);
    tick();
    cfg_we = 1'b0;
    if (s != 3) thr[f][s] = d;
  endtask
`endif

  initial begin
    for (int f = 0; f < 8; f++) begin
      thr[f][0] = 64;
      thr[f][1] = 128;
      thr[f][2] = 192;
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);
    vals = '{0, 63, 64, 127, 128, 191, 192, 255};
    run(8, 7);
    check("boundary_vec", 32'(feat_vec), 32'h0000FA50);
    result(0);
    vals = '{255, 255, 255, 0, 0, 0, 0, 0};
    run(3, 2);
    check("short_vec", 32'(feat_vec), 32'h0000003F);
    result(0);
    vals = '{200, 10, 70, 130, 250, 0, 64, 191};
    run(8, -1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd200;
    bus.in_last  = 1'b0;
    result(20);
    vals = '{200, 1, 2, 3, 4, 5, 6, 7};
    run(8, 7);
    check("stalled_beat_slot0", 32'(feat_vec[1:0]), 32'd3);
    result(0);
    vals = '{100, 150, 200, 250, 90, 0, 0, 0};
    for (int k = 0; k < 4; k++) beat(8'(vals[k]), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(vals[4]);
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_reset("rst_mid_sample");
    rst = 1'b0;
    repeat (10) tick();
    check("no_result_after_abort", 32'(bus.res_valid), 32'd0);
    check("idle_vec_after_abort", 32'(feat_vec), 32'd0);
    vals = '{255, 255, 255, 255, 255, 255, 255, 255};
    run(8, -1);
    rst = 1'b1;
    tick();
    check_reset("rst_in_out");
    rst = 1'b0;
    repeat (10) tick();
    check("no_result_after_out_rst", 32'(bus.res_valid), 32'd0);
    vals = '{0, 70, 130, 200, 0, 70, 130, 200};
    run(4, 3);
    check("clean_after_rst_vec", 32'(feat_vec), 32'h000000E4);
    result(0);
`ifdef TNN_THRESH_LOAD_EN
    cfg(2, 0, 10);
    vals = '{0, 0, 10, 0, 0, 0, 0, 0};
    run(3, 2);
    check("cfg_slot2_code", 32'(feat_vec[5:4]), 32'd1);
    result(0);
    cfg(2, 3, 0);
    vals = '{0, 0, 9, 0, 0, 0, 0, 0};
    run(3, 2);
    check("reserved_write_ignored", 32'(feat_vec[5:4]), 32'd0);
    result(0);
`endif
    mode = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int n;
      int lp;
      n  = int'($urandom_range(1, 8));
      lp = (n == 8 && $urandom_range(0, 1) == 1) ? -1 : n - 1;
      for (int k = 0; k < 8; k++) vals[k] = int'($urandom_range(0, 255));
      run(n, lp);
      result(int'($urandom_range(0, 3)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
